// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipe playfield and the renderer that displays it.
package pipe_pkg;
   typedef enum logic [1:0] {IDLE, RUN, HALT} pipe_state_t;

   localparam int GAP_OFFSET = 2;
   localparam int DEF_WIDTH  = 16;
   localparam int DEF_HEIGHT = 16;
endpackage

// File: rtl/pipe_column.sv
// Builds one pipe column from a 3-bit random value: solid rows with a GAP-row hole at rnd+GAP_OFFSET.
module pipe_column
   import pipe_pkg::*;
#(
   parameter int HEIGHT = DEF_HEIGHT,
   parameter int GAP    = 4
) (
   input  logic [2:0]        rnd,
   output logic [HEIGHT-1:0] col
);
   int gap_top;

   always_comb begin
      gap_top = int'(rnd) + GAP_OFFSET;
      col     = '1;
      for (int r = 0; r < HEIGHT; r++)
         if (r >= gap_top && r < gap_top + GAP) col[r] = 1'b0;
   end
endmodule

// File: rtl/pipe_scroller.sv
// Game FSM plus scrolling pipe playfield; inserts a random pipe every SPACING ticks and
// pulses point as each pipe's marker row leaves the bird's column.
module pipe_scroller
   import pipe_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int HEIGHT   = DEF_HEIGHT,
   parameter int GAP      = 4,
   parameter int SPACING  = 6,
   parameter int BIRD_COL = 3
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         tick,
   input  logic                         start,
   input  logic                         collide,
   input  logic [2:0]                   rnd,
   output logic [HEIGHT-1:0][WIDTH-1:0] pipes,
   output logic                         point,
   output logic                         running
);
   localparam int CW = $clog2(SPACING);
   localparam logic [CW-1:0] RELOAD = CW'(SPACING - 1);

   pipe_state_t       state;
   logic [CW-1:0]     spawn_cnt;
   logic [HEIGHT-1:0] new_col;
   logic              spawn;

   pipe_column #(.HEIGHT(HEIGHT), .GAP(GAP)) u_col (
      .rnd (rnd),
      .col (new_col)
   );

   assign spawn   = (spawn_cnt == '0);
   assign running = (state == RUN);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         pipes     <= '0;
         point     <= 1'b0;
         spawn_cnt <= RELOAD;
      end else begin
         point <= 1'b0;
         case (state)
            IDLE, HALT: begin
               // start beats a simultaneous collide outside RUN
               if (start) begin
                  state     <= RUN;
                  pipes     <= '0;
                  spawn_cnt <= RELOAD;
               end
            end
            RUN: begin
               if (collide) begin
                  state <= HALT;
               end else if (tick) begin
                  point <= pipes[0][BIRD_COL];
                  for (int r = 0; r < HEIGHT; r++)
                     pipes[r] <= {spawn ? new_col[r] : 1'b0, pipes[r][WIDTH-1:1]};
                  spawn_cnt <= spawn ? RELOAD : spawn_cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pipe_scroller.sv
// Directed bench for pipe_scroller at default parameters with hand-computed playfields.
module tb_pipe_scroller;
   logic                clk = 1'b0;
   logic                rst_n;
   logic                tick, start, collide;
   logic [2:0]          rnd;
   logic [15:0][15:0]   pipes;
   logic                point, running;
   logic [255:0]        exp_f;
   int                  tests = 0;
   int                  fails = 0;

   // Hand-derived pipe columns (bit r = row r)
   localparam logic [15:0] COL_R5 = 16'hF87F;  // gap rows 7..10
   localparam logic [15:0] COL_R0 = 16'hFFC3;  // gap rows 2..5
   localparam logic [15:0] COL_R3 = 16'hFE1F;  // gap rows 5..8
   localparam logic [15:0] COL_R7 = 16'hE1FF;  // gap rows 9..12

   pipe_scroller dut (
      .clk     (clk),
      .reset   (rst_n),
      .tick    (tick),
      .start   (start),
      .collide (collide),
      .rnd     (rnd),
      .pipes   (pipes),
      .point   (point),
      .running (running)
   );

   always #5 clk = ~clk;

   function automatic logic [255:0] place(input logic [15:0] v, input int c);
      logic [255:0] p;
      p = '0;
      for (int r = 0; r < 16; r++) p[r*16 + c] = v[r];
      return p;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs from a negedge, return at the following negedge.
   task automatic step(input logic t, input logic s, input logic c, input logic [2:0] r);
      tick = t; start = s; collide = c; rnd = r;
      @(posedge clk);
      #1;
      tick = 1'b0; start = 1'b0; collide = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; tick = 1'b0; start = 1'b0; collide = 1'b0; rnd = 3'd0;
      #2;
      chk("reset_pipes", pipes, '0);
      chk("reset_running", 256'(running), 256'd0);
      chk("reset_point", 256'(point), 256'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Ticks without start do nothing
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b0, 1'b0, 3'd5);
         chk("idle_point", 256'(point), 256'd0);
      end
      chk("idle_pipes", pipes, '0);
      chk("idle_running", 256'(running), 256'd0);

      step(1'b0, 1'b1, 1'b0, 3'd0);
      chk("start_running", 256'(running), 256'd1);

      // Ticks 1..5 empty, tick 6 inserts rnd=5
      for (int i = 1; i <= 5; i++) begin
         step(1'b1, 1'b0, 1'b0, 3'd7);
         chk("pre_spawn_pipes", pipes, '0);
      end
      step(1'b1, 1'b0, 1'b0, 3'd5);
      chk("tick6_pipes", pipes, place(COL_R5, 15));
      chk("tick6_running", 256'(running), 256'd1);

      // Ticks 7..11 must ignore rnd, tick 12 inserts rnd=0
      for (int i = 7; i <= 11; i++) step(1'b1, 1'b0, 1'b0, 3'd7);
      step(1'b1, 1'b0, 1'b0, 3'd0);
      chk("tick12_pipes", pipes, place(COL_R5, 9) | place(COL_R0, 15));

      // Ticks 13..25 (start at 13 ignored in RUN), inserts at 18 (rnd=3) and 24 (rnd=7)
      for (int t = 13; t <= 25; t++) begin
         step(1'b1, (t == 13), 1'b0, (t == 18) ? 3'd3 : (t == 24) ? 3'd7 : 3'd1);
         chk($sformatf("point_tick%0d", t), 256'(point), 256'((t == 19) || (t == 25)));
         if (t == 19 || t == 25) begin
            step(1'b0, 1'b0, 1'b0, 3'd0);
            chk("point_one_cycle", 256'(point), 256'd0);
         end
      end
      exp_f = place(COL_R0, 2) | place(COL_R3, 8) | place(COL_R7, 14);
      chk("tick25_pipes", pipes, exp_f);

      // tick+collide: collide wins, field frozen afterwards
      step(1'b1, 1'b0, 1'b1, 3'd0);
      chk("collide_pipes", pipes, exp_f);
      chk("collide_running", 256'(running), 256'd0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b0, 3'd0);
         chk("halt_point", 256'(point), 256'd0);
      end
      chk("halt_pipes", pipes, exp_f);

      // start+collide in HALT: start wins and clears
      step(1'b0, 1'b1, 1'b1, 3'd0);
      chk("restart_pipes", pipes, '0);
      chk("restart_running", 256'(running), 256'd1);
      for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 1'b0, 3'd2);
      chk("restart_pre_pipes", pipes, '0);
      step(1'b1, 1'b0, 1'b0, 3'd5);
      chk("restart_tick6_pipes", pipes, place(COL_R5, 15));

      // Asynchronous reset mid-cycle with a populated field
      step(1'b1, 1'b0, 1'b0, 3'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_pipes", pipes, '0);
      chk("async_rst_running", 256'(running), 256'd0);
      chk("async_rst_point", 256'(point), 256'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 3'd4);
      chk("post_rst_pipes", pipes, '0);
      chk("post_rst_running", 256'(running), 256'd0);
      step(1'b0, 1'b1, 1'b0, 3'd0);
      chk("post_rst_start", 256'(running), 256'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/pipe_scroller.md
# pipe_scroller

Consumer of the 3-bit pseudo-random stream from the game's LFSR: turns each sampled value into a pipe column with a randomly placed gap. Scrolls the pipe playfield one column left per game tick. Reports a score point each time a pipe clears the bird's column. Sits between the LFSR and the LED-matrix renderer and collision logic.

## Interface
Parameters:
- `WIDTH`, 16: playfield columns; column `WIDTH-1` is the entry (right) edge.
- `HEIGHT`, 16: playfield rows; row 0 is the top.
- `GAP`, 4: gap height in rows.
- `SPACING`, 6: ticks between pipe insertions. Must be ≥2.
- `BIRD_COL`, 3: column the bird occupies. Must be < `WIDTH-1`.
- Constraint: `2 + 7 + GAP ≤ HEIGHT`.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-cycle scroll strobe from the game-rate divider.
- `start`  in  1  one-cycle pulse: begin or restart the game.
- `collide`  in  1  one-cycle pulse from collision logic.
- `rnd`  in  3  current LFSR output; free-running, no handshake.
- `pipes`  out  `[HEIGHT-1:0][WIDTH-1:0]`  playfield; 1 = pipe pixel.
- `point`  out  1  one-cycle pulse when a pipe leaves `BIRD_COL`.
- `running`  out  1  high while in RUN.

## Operation
- States:
  - IDLE (after reset).
  - RUN.
  - HALT (after a collision).
- Transitions:
  - IDLE → RUN on `start`.
  - RUN → HALT on `collide`.
  - HALT → RUN on `start`.
  - All other inputs are ignored for transitions.
- On entering RUN from HALT: `pipes` is cleared and `spawn_cnt` is reloaded, both at the `start` edge.
- `spawn_cnt` is a down-counter, width `$clog2(SPACING)`. Reset/reload value is `SPACING-1`.
- On each `tick` in RUN:
  - Every column c < `WIDTH-1` takes the old value of column c+1. The old column 0 is discarded.
  - If `spawn_cnt==0`: column `WIDTH-1` gets a pipe column built from `rnd` sampled at that edge, and `spawn_cnt` reloads to `SPACING-1`.
  - Otherwise: column `WIDTH-1` gets all zeros and `spawn_cnt` decrements.
- Pipe column from value v:
  - `gap_top = v + 2`, range 2..9.
  - Rows `gap_top`..`gap_top+GAP-1` are 0; all other rows are 1.
  - Row 0 is therefore always 1 in a pipe column and 0 in an empty one. Row 0 is the pipe marker.
- `point` is registered. At a scroll edge, `point` ← `pipes[0][BIRD_COL]` (the old value). At every other edge it is 0.
- In IDLE and HALT, `tick` has no effect: `pipes` holds, `spawn_cnt` holds, `point` stays 0.
- Simultaneous events:
  - `tick` + `collide` in RUN: `collide` wins. No scroll, no point, go to HALT.
  - `start` + `collide` in IDLE/HALT: `start` wins.
  - `start` in RUN: ignored.
- Reset (asynchronous, any time, including mid-RUN):
  - `pipes` = 0, `point` = 0, `running` = 0, state = IDLE, `spawn_cnt` = `SPACING-1`.
  - Takes effect immediately, with no clock edge required.

## Timing
- All outputs are registered; `running` is decoded directly from the state register.
- Insertion latency: the pipe is visible in column `WIDTH-1` the cycle after the inserting `tick` edge.
- First pipe after `start`: on the `SPACING`-th tick.
- A pipe inserted at tick T occupies column `WIDTH-1-k` after tick T+k.
- `point` fires in the cycle after tick T + (`WIDTH-1-BIRD_COL`) + 1.
- `rnd` is sampled only on insertion edges; no other timing relationship with the LFSR exists.

## Structure
- Package `pipe_pkg`:
  - State enum `pipe_state_t` {IDLE, RUN, HALT}.
  - Constant `GAP_OFFSET = 2`.
  - Default `WIDTH`/`HEIGHT` constants shared with the renderer.
- Sub-module `pipe_column`: combinational `rnd` → `HEIGHT`-bit column, parameterised by `HEIGHT`/`GAP`. Reused by the renderer's preview.
- Top module holds the FSM, `spawn_cnt`, the shift array and the `point` register.

## Test plan
Defaults throughout: 16×16, GAP 4, SPACING 6, BIRD_COL 3.
- Reset then 10 ticks with no `start` → `pipes` all 0, `running` 0, `point` never high.
- `start`, then 6 ticks, `rnd`=3'b101 at the 6th → column 15 has rows 7..10 = 0, all other rows = 1; columns 0..14 = 0; `running` = 1.
- Continue with `rnd`=3'b000 at tick 12 → the first pipe is in column 9; column 15 has rows 2..5 = 0; columns 10..14 = 0.
- First pipe inserted at tick 6, then 13 more ticks → `point` high for exactly one cycle after tick 19, low otherwise. Subsequent pipes pulse every 6 ticks.
- `tick` and `collide` in the same cycle → `pipes` unchanged, `running` 0. Further ticks leave `pipes` frozen. `start` → `pipes` all 0, and the next pipe appears after 6 ticks.
- `reset` driven low mid-cycle during RUN with a populated field → `pipes` 0, `running` 0 and `point` 0 before the next `clk` edge. After release, the block stays in IDLE until `start`.
